// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 read port between the L1 instruction (0) and data (1) sides,
// round-robin under contention, with saturating hit/miss statistics.
module l2_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 11,
    parameter int L2_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_hit,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_hit,
    output logic              l2_read,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic [DATA_W-1:0] l2_read_data,
    input  logic              l2_hit,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy
);
    localparam int LW = $clog2(L2_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic rr_ptr, owner, hit_q, gnt1;
    logic [LW-1:0] cnt;
    // port 1 wins when it is the only requester or when it holds the round-robin token
    assign gnt1 = req1_valid && (!req0_valid || rr_ptr);
    assign req0_ready = (state == IDLE) && req0_valid && !gnt1;
    assign req1_ready = (state == IDLE) && gnt1;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= 1'b0;
            owner <= 1'b0;
            hit_q <= 1'b0;
            cnt <= '0;
            l2_read <= 1'b0;
            l2_addr <= '0;
            resp0_valid <= 1'b0;
            resp0_data <= '0;
            resp0_hit <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_data <= '0;
            resp1_hit <= 1'b0;
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            if (stat_clr) begin
                hit_count <= '0;
                miss_count <= '0;
            end else if (state == RESP) begin
                if (hit_q) hit_count <= hit_count + CNT_W'(hit_count != '1);
                else miss_count <= miss_count + CNT_W'(miss_count != '1);
            end
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    owner <= gnt1;
                    rr_ptr <= !gnt1;
                    l2_addr <= gnt1 ? req1_addr : req0_addr;
                    l2_read <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    l2_read <= 1'b0;
                    cnt <= LW'(L2_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - LW'(1);
                    if (cnt == LW'(1)) begin
                        hit_q <= l2_hit;
                        l2_addr <= '0;
                        resp0_valid <= !owner;
                        resp0_data <= owner ? '0 : l2_read_data;
                        resp0_hit <= !owner && l2_hit;
                        resp1_valid <= owner;
                        resp1_data <= owner ? l2_read_data : '0;
                        resp1_hit <= owner && l2_hit;
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp0_valid <= 1'b0;
                    resp0_data <= '0;
                    resp0_hit <= 1'b0;
                    resp1_valid <= 1'b0;
                    resp1_data <= '0;
                    resp1_hit <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed bench; u0 uses default parameters, u1 uses CNT_W=2 and L2_LAT=3.
module tb_l2_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic req_v [2][2];
    logic [10:0] req_a [2][2];
    logic rdy [2][2], rv [2][2], rh [2][2];
    logic [10:0] rd [2][2];
    logic l2r [2], l2h [2], clr [2], bsy [2];
    logic [10:0] l2a [2], l2d [2];
    logic [15:0] hc0, mc0;
    logic [1:0] hc1, mc1;
    int n_tests = 0, n_fail = 0;
    // L2 stub: data = addr ^ 7FF, hit only at address 50, one register stage
    always_ff @(posedge clk)
        for (int d = 0; d < 2; d++) begin
            l2d[d] <= l2a[d] ^ 11'h7FF;
            l2h[d] <= l2a[d] == 11'd50;
        end
    l2_port_arbiter u0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_v[0][0]), .req0_addr(req_a[0][0]), .req0_ready(rdy[0][0]),
        .resp0_valid(rv[0][0]), .resp0_data(rd[0][0]), .resp0_hit(rh[0][0]),
        .req1_valid(req_v[0][1]), .req1_addr(req_a[0][1]), .req1_ready(rdy[0][1]),
        .resp1_valid(rv[0][1]), .resp1_data(rd[0][1]), .resp1_hit(rh[0][1]),
        .l2_read(l2r[0]), .l2_addr(l2a[0]), .l2_read_data(l2d[0]), .l2_hit(l2h[0]),
        .stat_clr(clr[0]), .hit_count(hc0), .miss_count(mc0), .busy(bsy[0])
    );
    l2_port_arbiter #(.CNT_W(2), .L2_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_v[1][0]), .req0_addr(req_a[1][0]), .req0_ready(rdy[1][0]),
        .resp0_valid(rv[1][0]), .resp0_data(rd[1][0]), .resp0_hit(rh[1][0]),
        .req1_valid(req_v[1][1]), .req1_addr(req_a[1][1]), .req1_ready(rdy[1][1]),
        .resp1_valid(rv[1][1]), .resp1_data(rd[1][1]), .resp1_hit(rh[1][1]),
        .l2_read(l2r[1]), .l2_addr(l2a[1]), .l2_read_data(l2d[1]), .l2_hit(l2h[1]),
        .stat_clr(clr[1]), .hit_count(hc1), .miss_count(mc1), .busy(bsy[1])
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic reset_all;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    // returns at the negedge of the ISSUE cycle with valid already dropped
    task automatic issue(input int d, input int p, input logic [10:0] a);
        int w = 0;
        req_v[d][p] = 1'b1;
        req_a[d][p] = a;
        #1;
        while (!rdy[d][p] && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("accept", rdy[d][p], 1);
        @(negedge clk);
        req_v[d][p] = 1'b0;
    endtask
    task automatic txn(input int d, input int p, input logic [10:0] a, input int lat);
        issue(d, p, a);
        repeat (lat + 1) @(negedge clk);
        check("txn_valid", rv[d][p], 1);
        check("txn_other", rv[d][1-p], 0);
        check("txn_data", rd[d][p], a ^ 11'h7FF);
        check("txn_hit", rh[d][p], a == 11'd50);
        @(negedge clk);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int p, w;
        logic [10:0] a;
        logic saw;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0;
            for (int q = 0; q < 2; q++) begin
                req_v[d][q] = 1'b0;
                req_a[d][q] = '0;
            end
        end
        @(negedge clk);
        check("rst_busy", bsy[0], 0);
        check("rst_l2_read", l2r[0], 0);
        check("rst_l2_addr", l2a[0], 0);
        check("rst_resp", {rv[0][0], rv[0][1], rd[0][0], rd[0][1]}, 0);
        check("rst_counts", {hc0, mc0, hc1, mc1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // single request to address 50
        issue(0, 0, 11'd50);
        check("single_l2_read", l2r[0], 1);
        check("single_l2_addr", l2a[0], 50);
        @(negedge clk);
        check("single_read_once", l2r[0], 0);
        check("single_addr_hold", l2a[0], 50);
        @(negedge clk);
        check("single_valid", rv[0][0], 1);
        check("single_data", rd[0][0], 11'h7CD);
        check("single_hit", rh[0][0], 1);
        check("single_other", {rv[0][1], rd[0][1], rh[0][1]}, 0);
        check("single_addr_clear", l2a[0], 0);
        @(negedge clk);
        check("single_counts", {hc0, mc0}, {16'd1, 16'd0});
        check("single_idle", {bsy[0], rv[0][0], rd[0][0]}, 0);
        // simultaneous requests: port 0 first, port 1 four cycles later
        reset_all();
        req_v[0][0] = 1'b1; req_a[0][0] = 11'd60;
        req_v[0][1] = 1'b1; req_a[0][1] = 11'd70;
        #1;
        check("sim_grant0", {rdy[0][0], rdy[0][1]}, 2'b10);
        @(negedge clk);
        req_v[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        check("sim_resp0", {rv[0][0], rd[0][0], rh[0][0], rv[0][1]}, {1'b1, 11'h7C3, 1'b0, 1'b0});
        @(negedge clk);
        #1;
        check("sim_grant1", rdy[0][1], 1);
        @(negedge clk);
        req_v[0][1] = 1'b0;
        repeat (2) @(negedge clk);
        check("sim_resp1", {rv[0][1], rd[0][1], rh[0][1], rv[0][0]}, {1'b1, 11'h7B9, 1'b0, 1'b0});
        @(negedge clk);
        check("sim_counts", {hc0, mc0}, {16'd0, 16'd2});
        // round robin with both ports continuously valid
        reset_all();
        req_v[0][0] = 1'b1; req_a[0][0] = 11'd100;
        req_v[0][1] = 1'b1; req_a[0][1] = 11'd200;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            #1;
            while (!(rdy[0][0] || rdy[0][1]) && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            p = rdy[0][1] ? 1 : 0;
            check("rr_grant", p, k % 2);
            a = req_a[0][p];
            @(negedge clk);
            if (k == 5) begin
                req_v[0][0] = 1'b0;
                req_v[0][1] = 1'b0;
            end else req_a[0][p] = a + 11'd1;
            check("rr_busy_issue", bsy[0], 1);
            repeat (2) @(negedge clk);
            check("rr_busy_resp", bsy[0], 1);
            check("rr_owner", {rv[0][p], rv[0][1-p]}, 2'b10);
            check("rr_data", rd[0][p], a ^ 11'h7FF);
            @(negedge clk);
        end
        check("rr_done_busy", bsy[0], 0);
        check("rr_counts", mc0, 6);
        // reset asserted during WAIT
        reset_all();
        issue(0, 0, 11'd60);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bsy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw = saw | rv[0][0] | rv[0][1];
        end
        check("mid_rst_no_resp", saw, 0);
        check("mid_rst_counts", {hc0, mc0}, 0);
        txn(0, 0, 11'd80, 1);
        check("mid_rst_after", {hc0, mc0}, {16'd0, 16'd1});
        // L2_LAT=3: address held for ISSUE plus three WAIT cycles
        reset_all();
        issue(1, 1, 11'd50);
        check("lat_read", {l2r[1], l2a[1]}, {1'b1, 11'd50});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat_hold", {l2r[1], l2a[1], rv[1][1]}, {1'b0, 11'd50, 1'b0});
        end
        @(negedge clk);
        check("lat_resp", {rv[1][1], rd[1][1], rh[1][1]}, {1'b1, 11'h7CD, 1'b1});
        check("lat_addr_clear", l2a[1], 0);
        @(negedge clk);
        check("lat_counts", {bsy[1], hc1, mc1}, {1'b0, 2'd1, 2'd0});
        // saturation at 3 with CNT_W=2, then clear during a hit RESP
        for (int k = 0; k < 5; k++) txn(1, 0, 11'd10, 3);
        check("sat_miss", mc1, 3);
        check("sat_hit", hc1, 1);
        issue(1, 0, 11'd50);
        repeat (4) @(negedge clk);
        check("clr_resp", {rv[1][0], rh[1][0]}, 2'b11);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        check("clr_counts", {hc1, mc1}, 0);
        @(negedge clk);
        check("clr_stays", {hc1, mc1}, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single read port of the direct-mapped L2 cache between two requesters: port 0 (L1 instruction side) and port 1 (L1 data side).
- Accepts one request at a time and pulses the L2 read strobe.
- Waits the L2 lookup latency, captures data and hit, and returns them to the owning requester.
- Keeps saturating hit and miss statistics for the shared L2.

Parameters:
- ADDR_W, 11, address width (matches L2 addr).
- DATA_W, 11, data width (matches L2 read_data).
- L2_LAT, 1, cycles from the end of the L2 read strobe cycle to the edge on which l2_read_data/l2_hit are sampled. Must be >= 1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid  in  1  port 0 request; held with req0_addr until req0_ready.
- req0_addr  in  ADDR_W  port 0 address.
- req0_ready  out  1  port 0 request accepted this cycle.
- resp0_valid  out  1  one-cycle port 0 response strobe.
- resp0_data  out  DATA_W  port 0 read data.
- resp0_hit  out  1  port 0 L2 hit flag.
- req1_valid, req1_addr, req1_ready, resp1_valid, resp1_data, resp1_hit: same as port 0, for port 1.
- l2_read  out  1  L2 read strobe.
- l2_addr  out  ADDR_W  L2 address.
- l2_read_data  in  DATA_W  L2 data.
- l2_hit  in  1  L2 hit.
- stat_clr  in  1  synchronous clear of the counters.
- hit_count  out  CNT_W  L2 hits serviced.
- miss_count  out  CNT_W  L2 misses serviced.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - state=IDLE, rr_ptr=0.
  - All outputs 0; latched addr/owner/data/hit = 0; counters = 0.
  - Any in-flight request is dropped and produces no response.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Only port 0 valid: grant 0. Only port 1 valid: grant 1. Both valid: grant the port equal to rr_ptr.
  - reqN_ready = (state==IDLE) && granted(N). It is combinational and high for exactly one cycle.
  - On that edge: latch addr and owner, set rr_ptr = ~owner, go to ISSUE.
  - No valid: stay in IDLE.
- **ISSUE:**
  - l2_read=1 for exactly this one cycle.
  - l2_addr = latched addr; it stays stable from ISSUE through the end of WAIT and is 0 otherwise.
  - Load wait counter with L2_LAT. Go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 0, capture l2_read_data and l2_hit, then go to RESP. WAIT lasts exactly L2_LAT cycles.
- **RESP:**
  - resp<owner>_valid=1 for one cycle with the captured data/hit. The non-owner response outputs stay 0.
  - respN_data/respN_hit are 0 whenever respN_valid is 0.
  - On the same edge: hit_count++ if captured hit, else miss_count++. Go to IDLE.
- **Latency and throughput:**
  - If accept is in cycle t, the response appears in cycle t+2+L2_LAT.
  - Peak throughput is one request per 3+L2_LAT cycles.
  - A request pending during a busy period is accepted in the first IDLE cycle.
- **Fairness:** with both ports continuously valid, grants alternate 0,1,0,1...
- **Requester side:**
  - Deasserting valid before ready is legal; the arbiter makes no commitment.
  - valid/addr are ignored outside IDLE.
- **Counters:**
  - Each counter saturates at 2^CNT_W-1 (no wrap).
  - stat_clr zeroes both counters on the next edge and wins over a simultaneous RESP increment. The response itself is still delivered.
- **Reset mid-operation** (any state): return to IDLE next. No stale resp_valid after rst_n rises.

Test Plan:
- Bench L2 stub: read_data = addr ^ 11'h7FF, hit = (addr==50), registered with L2_LAT=1.
- **Single request:** port 0 addr=50 accepted at cycle t -> l2_read high at t+1 only with l2_addr=50; resp0_valid at t+3 with data=11'h7CD, hit=1; hit_count=1, miss_count=0.
- **Simultaneous requests:** ports 0 and 1 valid at the same time (addr 60 and 70) after reset -> port 0 granted first and port 1 accepted 4 cycles later. resp0 data=11'h7C3 hit=0, resp1 data=11'h7B9 hit=0; miss_count=2.
- **Round-robin under contention:** both ports valid continuously for 6 transactions -> grant order 0,1,0,1,0,1. Each response goes only to its owner; busy drops only after the last RESP.
- **Reset mid-operation:** rst_n pulsed low during WAIT -> no resp*_valid afterwards, counters 0. A new request to addr 80 then completes normally with miss_count=1.
- **Counter saturation and clear:** CNT_W=2 with 5 misses -> miss_count stays 3. stat_clr asserted in the RESP cycle of a hit -> hit_count=0 next cycle while resp_valid is still delivered.
- **Latency sweep:** L2_LAT=3 with port 1 addr=50 -> l2_addr held for 4 cycles and the response arrives at accept+5 with hit=1.
